clk_divider_multi: RTL and testbench

Parametrised multi-channel programmable clock divider running off the 10 MHz system clock. Each channel produces a divided square wave or a one-cycle pulse train, plus a rising-edge tick strobe. Divisor and mode changes are glitch-free and apply only at full-period boundaries. A global sync_restart phase-aligns all channels. Feeds slow-rate consumers (LED blink, sampling, display refresh) that each need an independent rate.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 72 +++++++
 rtl/clk_divider_multi.sv | 34 +++
 tb/tb_clk_divider_multi.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider: counter width, mode encodings and
// toggle-mode reload values for common rates off the 10 MHz system clock.
package clk_div_pkg;

    localparam int unsigned DIV_WIDTH = 24;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Toggle reload D gives f = 10 MHz / (2 * (D + 1))
    localparam logic [DIV_WIDTH-1:0] DIV_1HZ  = 24'd4_999_999;
    localparam logic [DIV_WIDTH-1:0] DIV_2HZ  = 24'd2_499_999;
    localparam logic [DIV_WIDTH-1:0] DIV_10HZ = 24'd499_999;
    localparam logic [DIV_WIDTH-1:0] DIV_50HZ = 24'd99_999;
    localparam logic [DIV_WIDTH-1:0] DIV_1KHZ = 24'd4_999;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: down-counter with shadowed divisor/mode so that changes only take
// effect at a rising reload, producing a square wave or a single-cycle pulse train.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk_10MHz,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] div,
    input  logic             sync_restart,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_div_q, shadow_div_d;
    logic             shadow_mode_q, shadow_mode_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    always_ff @(posedge clk_10MHz or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            shadow_div_q  <= '0;
            shadow_mode_q <= 1'b0;
            clk_out_q     <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shadow_div_q  <= shadow_div_d;
            shadow_mode_q <= shadow_mode_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        shadow_div_d  = shadow_div_q;
        shadow_mode_d = shadow_mode_q;
        clk_out_d     = clk_out_q;
        tick_d        = 1'b0;

        if (!en || sync_restart) begin
            // Park at cnt==0 with output low so the next enabled edge is a rising reload
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
            if (shadow_mode_q == MODE_PULSE) begin
                clk_out_d = 1'b0;
            end
        end else if (!clk_out_q || shadow_mode_q == MODE_PULSE) begin
            shadow_div_d  = div;
            shadow_mode_d = mode;
            cnt_d         = div;
            clk_out_d     = 1'b1;
            tick_d        = 1'b1;
        end else begin
            // Low half reuses the latched divisor so both halves match
            cnt_d     = shadow_div_q;
            clk_out_d = 1'b0;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: NCH independent channels sharing a phase-aligning
// sync_restart.
module clk_divider_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                 clk_10MHz,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       mode,
    input  logic [NCH*WIDTH-1:0] div,
    input  logic                 sync_restart,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk_10MHz   (clk_10MHz),
            .rst         (rst),
            .en          (en[i]),
            .mode        (mode[i]),
            .div         (div[i*WIDTH +: WIDTH]),
            .sync_restart(sync_restart),
            .clk_out     (clk_out[i]),
            .tick        (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: directed scenarios plus random traffic, all
// compared against a period-position reference model.
module tb_clk_divider_multi;
    import clk_div_pkg::*;

    localparam int NCH   = 2;
    localparam int WIDTH = 24;

    logic                 clk_10MHz = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       mode;
    logic [NCH*WIDTH-1:0] div;
    logic                 sync_restart;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;

    int n_test = 0;
    int n_fail = 0;

    clk_divider_multi #(
        .NCH  (NCH),
        .WIDTH(WIDTH)
    ) dut (
        .clk_10MHz   (clk_10MHz),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .div         (div),
        .sync_restart(sync_restart),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    always #50 clk_10MHz = ~clk_10MHz;

    // Reference model: each active channel sits at position pos within a period of plen
    // cycles, the period's D and mode being captured when the period starts.
    bit      act  [NCH];
    longint  pos  [NCH];
    longint  plen [NCH];
    longint  pd   [NCH];
    bit      pm   [NCH];

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) act[i] = 0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            if (rst || !en[i] || sync_restart) begin
                act[i] = 0;
            end else if (!act[i] || pos[i] == plen[i] - 1) begin
                act[i]  = 1;
                pd[i]   = longint'(div[i*WIDTH +: WIDTH]);
                pm[i]   = mode[i];
                plen[i] = pm[i] ? pd[i] + 1 : 2 * (pd[i] + 1);
                pos[i]  = 0;
            end else begin
                pos[i]++;
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_out();
        logic [NCH-1:0] v = '0;
        for (int i = 0; i < NCH; i++)
            if (act[i]) v[i] = pm[i] ? (pos[i] == 0) : (pos[i] <= pd[i]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_tick();
        logic [NCH-1:0] v = '0;
        for (int i = 0; i < NCH; i++)
            if (act[i]) v[i] = (pos[i] == 0);
        return v;
    endfunction

    // Advance one clock edge; returns 1 ns after the edge with the model updated
    task automatic step();
        model_edge();
        @(posedge clk_10MHz);
        #1;
    endtask

    task automatic set_div(input int ch, input logic [WIDTH-1:0] d);
        div[ch*WIDTH +: WIDTH] = d;
    endtask

    task automatic idle();
        en = '0;
        sync_restart = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = '1;
        mode = '0;
        div = '0;
        sync_restart = 1'b0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            step();
            n_test++;
            if (clk_out !== 2'b00 || tick !== 2'b00) begin
                n_fail++;
                $display("FAIL reset cyc%0d clk_out=%b tick=%b required 00/00", c, clk_out, tick);
            end
        end
        #20 rst = 1'b0;
        idle();
    endtask

    task automatic test_toggle();
        int rises = 0, ticks = 0;
        logic prev = 1'b0;
        set_div(0, 24'd4);
        mode[0] = MODE_TOGGLE;
        en = 2'b01;
        for (int c = 0; c < 30; c++) begin
            step();
            n_test++;
            if (clk_out !== exp_out() || tick !== exp_tick()) begin
                n_fail++;
                $display("FAIL toggle cyc%0d clk_out=%b tick=%b required %b/%b",
                         c, clk_out, tick, exp_out(), exp_tick());
            end
            if (c == 0) begin
                n_test++;
                if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL toggle_first_rise clk_out=%b tick=%b required 1/1",
                             clk_out[0], tick[0]);
                end
            end
            if (clk_out[0] && !prev) rises++;
            if (tick[0]) ticks++;
            prev = clk_out[0];
        end
        n_test++;
        if (rises != 3 || ticks != 3) begin
            n_fail++;
            $display("FAIL toggle_count rises=%0d ticks=%0d required 3/3", rises, ticks);
        end
        idle();
    endtask

    task automatic test_pulse();
        int highs = 0;
        set_div(1, 24'd3);
        mode[1] = MODE_PULSE;
        en = 2'b10;
        for (int c = 0; c < 28; c++) begin
            if (c == 16) set_div(1, 24'd0);
            step();
            n_test++;
            if (clk_out !== exp_out() || tick !== exp_tick() || tick[1] !== clk_out[1]) begin
                n_fail++;
                $display("FAIL pulse cyc%0d clk_out=%b tick=%b required %b/%b",
                         c, clk_out, tick, exp_out(), exp_tick());
            end
            if (c < 16 && clk_out[1]) highs++;
            if (c >= 16 && clk_out[1]) highs += 100;
        end
        n_test++;
        if (highs != 4 + 12 * 100) begin
            n_fail++;
            $display("FAIL pulse_count got=%0d required %0d", highs, 4 + 1200);
        end
        idle();
    endtask

    task automatic test_div_change();
        logic s [32];
        int runs [4];
        int r = 0;
        set_div(0, 24'd4);
        mode[0] = MODE_TOGGLE;
        en = 2'b01;
        for (int c = 0; c < 32; c++) begin
            if (c == 2) set_div(0, 24'd9);
            step();
            s[c] = clk_out[0];
            n_test++;
            if (clk_out !== exp_out() || tick !== exp_tick()) begin
                n_fail++;
                $display("FAIL div_change cyc%0d clk_out=%b tick=%b required %b/%b",
                         c, clk_out, tick, exp_out(), exp_tick());
            end
        end
        for (int k = 0; k < 4; k++) runs[k] = 0;
        for (int c = 0; c < 32 && r < 4; c++) begin
            runs[r]++;
            if (c < 31 && s[c+1] != s[c]) r++;
        end
        n_test++;
        if (runs[0] != 5 || runs[1] != 5 || runs[2] != 10 || runs[3] != 10) begin
            n_fail++;
            $display("FAIL div_change_runs got %0d/%0d/%0d/%0d required 5/5/10/10",
                     runs[0], runs[1], runs[2], runs[3]);
        end
        idle();
    endtask

    task automatic test_sync_restart();
        set_div(0, 24'd2);
        set_div(1, 24'd5);
        mode = 2'b00;
        en = 2'b01;
        step();
        step();
        en = 2'b11;
        for (int c = 0; c < 4; c++) step();
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        n_test++;
        if (clk_out !== 2'b00 || tick !== 2'b00 || clk_out !== exp_out()) begin
            n_fail++;
            $display("FAIL sync_low clk_out=%b tick=%b required 00/00", clk_out, tick);
        end
        step();
        n_test++;
        if (clk_out !== 2'b11 || tick !== 2'b11 || tick !== exp_tick()) begin
            n_fail++;
            $display("FAIL sync_rise clk_out=%b tick=%b required 11/11", clk_out, tick);
        end
        for (int c = 0; c < 12; c++) begin
            step();
            n_test++;
            if (clk_out !== exp_out() || tick !== exp_tick()) begin
                n_fail++;
                $display("FAIL sync_run cyc%0d clk_out=%b tick=%b required %b/%b",
                         c, clk_out, tick, exp_out(), exp_tick());
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        set_div(0, 24'd4);
        mode[0] = MODE_TOGGLE;
        en = 2'b01;
        step();
        step();
        #20 rst = 1'b1;
        model_clear();
        #1;
        n_test++;
        if (clk_out !== 2'b00 || tick !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset clk_out=%b tick=%b required 00/00", clk_out, tick);
        end
        #10 rst = 1'b0;
        step();
        n_test++;
        if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1 || clk_out !== exp_out()) begin
            n_fail++;
            $display("FAIL reset_reenable clk_out=%b tick=%b required 1/1", clk_out[0], tick[0]);
        end
        idle();
    endtask

    task automatic test_enable_drop();
        set_div(0, 24'd4);
        mode[0] = MODE_TOGGLE;
        en = 2'b01;
        for (int c = 0; c < 3; c++) step();
        en[0] = 1'b0;
        step();
        n_test++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0 || clk_out !== exp_out()) begin
            n_fail++;
            $display("FAIL en_drop clk_out=%b tick=%b required 0/0", clk_out[0], tick[0]);
        end
        en[0] = 1'b1;
        step();
        n_test++;
        if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1 || tick !== exp_tick()) begin
            n_fail++;
            $display("FAIL en_resume clk_out=%b tick=%b required 1/1", clk_out[0], tick[0]);
        end
        idle();
    endtask

    task automatic test_1khz();
        int rise_at [$];
        int highs = 0;
        logic prev = 1'b0;
        set_div(0, DIV_1KHZ);
        mode[0] = MODE_TOGGLE;
        en = 2'b01;
        for (int c = 0; c < 30001; c++) begin
            step();
            n_test++;
            if (clk_out !== exp_out() || tick !== exp_tick()) begin
                n_fail++;
                $display("FAIL khz cyc%0d clk_out=%b tick=%b required %b/%b",
                         c, clk_out, tick, exp_out(), exp_tick());
            end
            if (clk_out[0] && !prev) rise_at.push_back(c);
            if (c < 10000 && clk_out[0]) highs++;
            prev = clk_out[0];
        end
        n_test++;
        if (rise_at.size() != 4 || highs != 5000) begin
            n_fail++;
            $display("FAIL khz_rises got=%0d highs=%0d required 4/5000", rise_at.size(), highs);
        end else begin
            for (int k = 1; k < 4; k++) begin
                n_test++;
                if (rise_at[k] - rise_at[k-1] != 10000) begin
                    n_fail++;
                    $display("FAIL khz_period%0d got=%0d required 10000",
                             k, rise_at[k] - rise_at[k-1]);
                end
            end
        end
        idle();
    endtask

    task automatic test_random();
        en = 2'b11;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
                if ($urandom_range(0, 9) == 0) mode[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) set_div(i, WIDTH'($urandom_range(0, 7)));
            end
            sync_restart = ($urandom_range(0, 39) == 0);
            step();
            n_test++;
            if (clk_out !== exp_out() || tick !== exp_tick()) begin
                n_fail++;
                $display("FAIL random cyc%0d clk_out=%b tick=%b required %b/%b",
                         c, clk_out, tick, exp_out(), exp_tick());
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_pulse();
        test_div_change();
        test_sync_restart();
        test_async_reset();
        test_enable_drop();
        test_1khz();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
